// File: rtl/vga_sync.sv
// VGA raster timing generator.
// A clock divider produces the pixel-enable strobe p_tick. On each strobe the
// horizontal position x advances, and y advances when x wraps. hsync, vsync,
// video_on and frame_start are registered from the next-state counter values,
// so they always describe the (x,y) that is presented in the same cycle.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 2     // clk cycles per pixel, 1..4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [1:0] div_cnt;
    logic [1:0] div_nxt;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       x_wrap;
    logic       y_wrap;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       video_on_nxt;
    logic       frame_start_nxt;

    // The strobe is a pure decode of the divider, so it tracks div_cnt in reset too.
    assign p_tick = (div_cnt == DIV_LAST);
    assign x_wrap = (x == X_LAST);
    assign y_wrap = (y == Y_LAST);

    // Next divider/position values and the sync/visibility decode of that next position.
    always_comb begin
        div_nxt         = div_cnt + 2'd1;
        x_nxt           = x;
        y_nxt           = y;
        frame_start_nxt = 1'b0;
        if (p_tick) begin
            div_nxt = 2'd0;
            if (x_wrap) begin
                x_nxt = 10'd0;
                if (y_wrap) begin
                    y_nxt           = 10'd0;
                    frame_start_nxt = 1'b1;
                end else begin
                    y_nxt = y + 10'd1;
                end
            end else begin
                x_nxt = x + 10'd1;
            end
        end
        hsync_nxt    = !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
        vsync_nxt    = !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
        video_on_nxt = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
    end

    // Counter and registered output update; reset wins over any pending advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= 2'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            video_on    <= video_on_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: a default-timing instance for reset release and
// one full line, plus two small-timing instances (PIX_DIV=2 and PIX_DIV=1)
// checked cycle by cycle against a closed-form raster position over several
// frames, including a mid-frame reset with an advance pending.
module tb_vga_sync;

    // Small raster: H 8+2+3+2 = 15, V 6+1+2+1 = 10.
    localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_D = 6, SV_F = 1, SV_S = 2, SV_B = 1;
    localparam int S_HT = 15;
    localparam int S_VT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_def, rst_n_sm, rst_n_p1;
    logic [9:0] def_x, def_y, sm_x, sm_y, p1_x, p1_y;
    logic       def_hs, def_vs, def_vo, def_pt, def_fs;
    logic       sm_hs, sm_vs, sm_vo, sm_pt, sm_fs;
    logic       p1_hs, p1_vs, p1_vo, p1_pt, p1_fs;

    vga_sync u_def (
        .clk(clk), .rst_n(rst_n_def), .x(def_x), .y(def_y), .hsync(def_hs),
        .vsync(def_vs), .video_on(def_vo), .p_tick(def_pt), .frame_start(def_fs)
    );

    vga_sync #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .PIX_DIV(2)
    ) u_sm (
        .clk(clk), .rst_n(rst_n_sm), .x(sm_x), .y(sm_y), .hsync(sm_hs),
        .vsync(sm_vs), .video_on(sm_vo), .p_tick(sm_pt), .frame_start(sm_fs)
    );

    vga_sync #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .PIX_DIV(1)
    ) u_p1 (
        .clk(clk), .rst_n(rst_n_p1), .x(p1_x), .y(p1_y), .hsync(p1_hs),
        .vsync(p1_vs), .video_on(p1_vo), .p_tick(p1_pt), .frame_start(p1_fs)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected small-raster outputs n clk cycles after reset release (n=0 is the
    // first cycle with rst_n high).
    task automatic check_pos(input string who, input int n, input int pd,
                             input logic [9:0] ox, input logic [9:0] oy,
                             input logic ohs, input logic ovs, input logic ovo,
                             input logic opt, input logic ofs);
        int p, ex, ey;
        p  = n / pd;
        ex = p % S_HT;
        ey = (p / S_HT) % S_VT;
        check({who, ".x"}, 32'(ox), 32'(ex));
        check({who, ".y"}, 32'(oy), 32'(ey));
        check({who, ".hsync"}, 32'(ohs), 32'(!(ex >= 10 && ex <= 12)));
        check({who, ".vsync"}, 32'(ovs), 32'(!(ey >= 7 && ey <= 8)));
        check({who, ".video_on"}, 32'(ovo), 32'(ex < 8 && ey < 6));
        check({who, ".p_tick"}, 32'(opt), 32'((n % pd) == (pd - 1)));
        check({who, ".frame_start"}, 32'(ofs), 32'(n > 0 && (n % (S_HT * S_VT * pd)) == 0));
    endtask

    int exp_pt[5] = '{0, 1, 0, 1, 0};
    int exp_x[5]  = '{0, 0, 1, 1, 2};
    int hs_cnt, hs_min, hs_max, vo_fall_x, wrap_y, y_bad, fs_cnt, prev_x, found;
    logic prev_vo;
    int sm_fs_cnt, p1_fs_cnt, sm_first_fs, sm_last_fs, p1_first_fs, p1_last_fs;

    initial begin
        // ---- reset state ----
        rst_n_def = 1'b0;
        rst_n_sm  = 1'b0;
        rst_n_p1  = 1'b0;
        repeat (3) tick();
        check("rst.x", 32'(def_x), 0);
        check("rst.y", 32'(def_y), 0);
        check("rst.hsync", 32'(def_hs), 1);
        check("rst.vsync", 32'(def_vs), 1);
        check("rst.video_on", 32'(def_vo), 1);
        check("rst.frame_start", 32'(def_fs), 0);
        check("rst.p_tick", 32'(def_pt), 0);
        check("rst.p1_p_tick", 32'(p1_pt), 1);
        check("rst.sm_frame_start", 32'(sm_fs), 0);

        // ---- default instance: release sequence ----
        rst_n_def = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            check("rel.p_tick", 32'(def_pt), 32'(exp_pt[i]));
            check("rel.x", 32'(def_x), 32'(exp_x[i]));
            check("rel.y", 32'(def_y), 0);
            check("rel.hsync", 32'(def_hs), 1);
            check("rel.vsync", 32'(def_vs), 1);
            check("rel.video_on", 32'(def_vo), 1);
            check("rel.frame_start", 32'(def_fs), 0);
        end

        // ---- default instance: rest of line 0 up to the wrap ----
        hs_cnt = 0; hs_min = 9999; hs_max = -1; vo_fall_x = -1; wrap_y = -1;
        y_bad = 0; fs_cnt = 0; prev_x = 2; prev_vo = 1'b1; found = 0;
        for (int i = 0; i < 1700 && found == 0; i++) begin
            tick();
            if (def_fs) fs_cnt++;
            if (prev_x == 799 && def_x == 0) begin
                wrap_y = int'(def_y);
                found  = 1;
            end else begin
                if (def_y != 0) y_bad++;
                if (!def_hs) begin
                    hs_cnt++;
                    if (int'(def_x) < hs_min) hs_min = int'(def_x);
                    if (int'(def_x) > hs_max) hs_max = int'(def_x);
                end
                if (prev_vo && !def_vo && vo_fall_x < 0) vo_fall_x = int'(def_x);
                prev_vo = def_vo;
                prev_x  = int'(def_x);
            end
        end
        check("line.wrap_reached", 32'(found), 1);
        check("line.video_off_x", 32'(vo_fall_x), 640);
        check("line.hsync_low_clks", 32'(hs_cnt), 192);
        check("line.hsync_first_x", 32'(hs_min), 656);
        check("line.hsync_last_x", 32'(hs_max), 751);
        check("line.y_after_wrap", 32'(wrap_y), 1);
        check("line.y_stable", 32'(y_bad), 0);
        check("line.no_frame_start", 32'(fs_cnt), 0);
        check("line.video_on_line1", 32'(def_vo), 1);

        // ---- small instances: several frames, cycle by cycle ----
        rst_n_sm = 1'b1;
        rst_n_p1 = 1'b1;
        sm_fs_cnt = 0; p1_fs_cnt = 0;
        sm_first_fs = -1; sm_last_fs = -1; p1_first_fs = -1; p1_last_fs = -1;
        for (int n = 0; n < 650; n++) begin
            if (n > 0) tick();
            check_pos("sm", n, 2, sm_x, sm_y, sm_hs, sm_vs, sm_vo, sm_pt, sm_fs);
            check_pos("p1", n, 1, p1_x, p1_y, p1_hs, p1_vs, p1_vo, p1_pt, p1_fs);
            if (sm_fs) begin
                sm_fs_cnt++;
                if (sm_first_fs < 0) sm_first_fs = n;
                sm_last_fs = n;
            end
            if (p1_fs) begin
                p1_fs_cnt++;
                if (p1_first_fs < 0) p1_first_fs = n;
                p1_last_fs = n;
            end
        end
        check("sm.frame_pulses", 32'(sm_fs_cnt), 2);
        check("sm.frame_period", 32'(sm_last_fs - sm_first_fs), 300);
        check("p1.frame_pulses", 32'(p1_fs_cnt), 4);
        check("p1.frame_period", 32'(p1_last_fs - p1_first_fs), 450);

        // ---- mid-frame reset inside both sync pulses with an advance pending ----
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (sm_x == 10'd12 && sm_y == 10'd8 && sm_pt) found = 1;
        end
        check("mid.position_reached", 32'(found), 1);
        check("mid.hsync_before", 32'(sm_hs), 0);
        check("mid.vsync_before", 32'(sm_vs), 0);
        rst_n_sm = 1'b0;
        fs_cnt = 0;
        tick();
        check("mid.x", 32'(sm_x), 0);
        check("mid.y", 32'(sm_y), 0);
        check("mid.hsync", 32'(sm_hs), 1);
        check("mid.vsync", 32'(sm_vs), 1);
        check("mid.video_on", 32'(sm_vo), 1);
        check("mid.p_tick", 32'(sm_pt), 0);
        check("mid.frame_start", 32'(sm_fs), 0);
        tick();
        tick();
        check("mid.frame_start_held", 32'(sm_fs), 0);
        rst_n_sm = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) tick();
            check_pos("mid_rel", n, 2, sm_x, sm_y, sm_hs, sm_vs, sm_vo, sm_pt, sm_fs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
